uart_frame_sched: RTL and testbench

//  Sequences one telemetry frame per frame_tick over the board-to-board UART link.

---
 rtl/uart_frame_sched.sv | 189 ++++++++++++++++++
 tb/tb_uart_frame_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sched.sv
// uart_frame_sched: sequences one telemetry frame per frame_tick over the
// board-to-board UART link. It steps the word multiplexer through word_idx,
// splits each 16-bit word into two bytes (high byte first) for uart_tx, and
// runs a watchdog on received sync keywords. While the link is down only
// word 0 (the sync word) is sent in each frame.
module uart_frame_sched #(
    parameter int NUM_WORDS = 8,
    parameter int MUX_LAT   = 1,
    parameter int TIMEOUT   = 6500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick_i,
    input  logic [15:0] word_data_i,
    input  logic        tx_busy_i,
    input  logic        tx_done_i,
    input  logic        rx_sync_i,
    output logic [3:0]  word_idx_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    output logic        frame_active_o,
    output logic        frame_overrun_o,
    output logic        con_broken_o
);

    localparam int MW = $clog2(MUX_LAT + 1) + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    LAST_FULL = 4'(NUM_WORDS - 1);
    localparam logic [MW-1:0] MUX_END   = MW'(MUX_LAT);
    localparam logic [CW-1:0] WD_END    = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEND_HI = 3'd2,
        S_WAIT_HI = 3'd3,
        S_SEND_LO = 3'd4,
        S_WAIT_LO = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     word_idx_q, word_idx_d;
    logic [3:0]     last_q, last_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_start_q, tx_start_d;
    logic           frame_active_q, frame_active_d;
    logic           overrun_q, overrun_d;
    logic           pending_q, pending_d;
    logic [MW-1:0]  mux_cnt_q, mux_cnt_d;
    logic [15:0]    hold_q, hold_d;
    logic [CW-1:0]  wd_cnt_q, wd_cnt_d;
    logic           con_broken_q, con_broken_d;

    // Frame sequencer next-state: word stepping, byte launch and tick queuing.
    always_comb begin
        state_d        = state_q;
        word_idx_d     = word_idx_q;
        last_d         = last_q;
        tx_data_d      = tx_data_q;
        tx_start_d     = 1'b0;
        frame_active_d = frame_active_q;
        mux_cnt_d      = mux_cnt_q;
        hold_d         = hold_q;
        // A tick during an active frame queues one frame; a second one is dropped.
        pending_d      = pending_q | (frame_tick_i & frame_active_q);
        overrun_d      = frame_tick_i & frame_active_q & pending_q;

        case (state_q)
            S_IDLE: begin
                if (frame_tick_i || pending_q) begin
                    word_idx_d     = 4'd0;
                    pending_d      = 1'b0;
                    frame_active_d = 1'b1;
                    // Frame length is fixed at frame start from the link state.
                    last_d         = con_broken_q ? 4'd0 : LAST_FULL;
                    mux_cnt_d      = '0;
                    state_d        = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // The mux needs MUX_LAT cycles after word_idx moves; sample one
                // cycle after that so a registered mux output is settled.
                if (mux_cnt_q == MUX_END) begin
                    hold_d  = word_data_i;
                    state_d = S_SEND_HI;
                end else begin
                    mux_cnt_d = mux_cnt_q + MW'(1);
                end
            end
            S_SEND_HI: begin
                if (!tx_busy_i) begin
                    tx_data_d  = hold_q[15:8];
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT_HI;
                end else begin
                    state_d = S_SEND_HI;
                end
            end
            S_WAIT_HI: begin
                if (tx_done_i) begin
                    state_d = S_SEND_LO;
                end else begin
                    state_d = S_WAIT_HI;
                end
            end
            S_SEND_LO: begin
                if (!tx_busy_i) begin
                    tx_data_d  = hold_q[7:0];
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT_LO;
                end else begin
                    state_d = S_SEND_LO;
                end
            end
            S_WAIT_LO: begin
                if (tx_done_i) begin
                    if (word_idx_q == last_q) begin
                        frame_active_d = 1'b0;
                        state_d        = S_IDLE;
                    end else begin
                        word_idx_d = word_idx_q + 4'd1;
                        mux_cnt_d  = '0;
                        state_d    = S_LOAD;
                    end
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Link watchdog next-state: a sync keyword always wins over expiry.
    always_comb begin
        wd_cnt_d     = wd_cnt_q;
        con_broken_d = con_broken_q;
        if (rx_sync_i) begin
            wd_cnt_d     = '0;
            con_broken_d = 1'b0;
        end else if (wd_cnt_q == WD_END) begin
            con_broken_d = 1'b1;
        end else begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
    end

    // State and output registers with synchronous reset; link starts down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            word_idx_q     <= 4'd0;
            last_q         <= 4'd0;
            tx_data_q      <= 8'd0;
            tx_start_q     <= 1'b0;
            frame_active_q <= 1'b0;
            overrun_q      <= 1'b0;
            pending_q      <= 1'b0;
            mux_cnt_q      <= '0;
            hold_q         <= 16'd0;
            wd_cnt_q       <= '0;
            con_broken_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            word_idx_q     <= word_idx_d;
            last_q         <= last_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            frame_active_q <= frame_active_d;
            overrun_q      <= overrun_d;
            pending_q      <= pending_d;
            mux_cnt_q      <= mux_cnt_d;
            hold_q         <= hold_d;
            wd_cnt_q       <= wd_cnt_d;
            con_broken_q   <= con_broken_d;
        end
    end

    assign word_idx_o      = word_idx_q;
    assign tx_data_o       = tx_data_q;
    assign tx_start_o      = tx_start_q;
    assign frame_active_o  = frame_active_q;
    assign frame_overrun_o = overrun_q;
    assign con_broken_o    = con_broken_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Bench for uart_frame_sched: a byte-stream scoreboard plus watchdog/overrun
// rules, with a registered word mux and a 10-cycles-per-byte uart peer.
module tb_uart_frame_sched;

    localparam int NW = 8;
    localparam int ML = 1;
    localparam int TO = 100;
    localparam int BYTE_CYC = 10;

    logic        clk = 1'b0;
    logic        rst, frame_tick, rx_sync, force_busy;
    logic [15:0] word_data;
    logic        tx_busy, tx_done;
    logic [3:0]  word_idx;
    logic [7:0]  tx_data;
    logic        tx_start, frame_active, frame_overrun, con_broken;

    always #5 clk = ~clk;

    uart_frame_sched #(.NUM_WORDS(NW), .MUX_LAT(ML), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .frame_tick_i(frame_tick), .word_data_i(word_data),
        .tx_busy_i(tx_busy), .tx_done_i(tx_done), .rx_sync_i(rx_sync),
        .word_idx_o(word_idx), .tx_data_o(tx_data), .tx_start_o(tx_start),
        .frame_active_o(frame_active), .frame_overrun_o(frame_overrun),
        .con_broken_o(con_broken)
    );

    // Word multiplexer: one registered stage (MUX_LAT = 1).
    logic [15:0] word_tab [0:15];
    always @(posedge clk) word_data <= word_tab[word_idx];

    // uart_tx peer: busy from the cycle after tx_start, done pulse after BYTE_CYC.
    int ucnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            ucnt <= 0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_start && ucnt == 0) ucnt <= BYTE_CYC;
            else if (ucnt > 0) begin
                ucnt <= ucnt - 1;
                if (ucnt == 1) tx_done <= 1'b1;
            end
        end
    end
    assign tx_busy = (ucnt != 0) || force_busy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state (frame/byte level)
    bit          armed = 0, just_reset = 0;
    bit          m_active, m_pending, m_broken, m_overrun, outstanding, ended;
    int          m_sync_age;
    logic [11:0] q[$];
    logic [11:0] e;
    logic [7:0]  held_data;
    logic [3:0]  held_idx;
    bit          prev_start, prev_busy;
    int          n_starts = 0, n_overrun = 0, n_frames = 0;
    logic [7:0]  cap[$];
    logic [3:0]  cap_idx[$];

    // Compare process: check this cycle's outputs, then predict the next edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("frame_active", frame_active, m_active);
            chk("con_broken", con_broken, m_broken);
            chk("frame_overrun", frame_overrun, m_overrun);
            if (just_reset) begin
                chk("rst_tx_data", tx_data, 8'd0);
                chk("rst_word_idx", word_idx, 4'd0);
                chk("rst_tx_start", tx_start, 1'b0);
            end
            if (frame_overrun === 1'b1) n_overrun++;
            if (tx_start === 1'b1) begin
                chk("start_pulse_width", prev_start, 1'b0);
                chk("start_while_busy", prev_busy, 1'b0);
                chk("start_before_done", outstanding, 1'b0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_extra_byte actual=%0h required=none t=%0t", tx_data, $time);
                end else begin
                    e = q.pop_front();
                    chk("tx_data", tx_data, e[7:0]);
                    chk("word_idx", word_idx, e[11:8]);
                end
                cap.push_back(tx_data);
                cap_idx.push_back(word_idx);
                n_starts++;
                outstanding = 1;
                held_data = tx_data;
                held_idx = word_idx;
            end else if (outstanding) begin
                chk("tx_data_stable", tx_data, held_data);
                chk("word_idx_stable", word_idx, held_idx);
            end
        end
        prev_start = (tx_start === 1'b1);
        prev_busy = tx_busy;
        if (rst) begin
            armed = 1; just_reset = 1;
            m_active = 0; m_pending = 0; m_overrun = 0; m_broken = 1;
            m_sync_age = -1; outstanding = 0; prev_start = 0;
            q.delete();
        end else begin
            just_reset = 0;
            m_overrun = 0;
            ended = 0;
            if (tx_done && outstanding) begin
                outstanding = 0;
                if (m_active && q.size() == 0) ended = 1;
            end
            if (m_active) begin
                if (frame_tick) begin
                    if (m_pending) m_overrun = 1;
                    else m_pending = 1;
                end
            end else if (frame_tick || m_pending) begin
                m_pending = 0;
                m_active = 1;
                n_frames++;
                for (int k = 0; k <= (m_broken ? 0 : NW - 1); k++) begin
                    q.push_back({4'(k), word_tab[k][15:8]});
                    q.push_back({4'(k), word_tab[k][7:0]});
                end
            end
            if (ended) m_active = 0;
            if (rx_sync) begin
                m_sync_age = 0;
                m_broken = 0;
            end else if (m_sync_age >= 0) begin
                if (m_sync_age <= TO) m_sync_age++;
                m_broken = (m_sync_age >= TO + 1);
            end else begin
                m_broken = 1;
            end
        end
    end

    task automatic pulse_tick;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic pulse_sync;
        rx_sync = 1'b1;
        @(posedge clk); #1;
        rx_sync = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((frame_active !== 1'b0 || m_active || m_pending) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout actual=%0d required=<%0d", n, budget);
        end
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (n_starts < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_starts_timeout actual=%0d required=%0d", n_starts, target);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1);
    end

    initial begin
        int base, sb, ov0, fr0, fb_cnt;
        rst = 1'b1; frame_tick = 1'b0; rx_sync = 1'b0; force_busy = 1'b0;
        for (int k = 0; k < 16; k++) word_tab[k] = 16'hA000 + 16'(k);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_con_broken", con_broken, 1'b1);
        chk("reset_frame_active", frame_active, 1'b0);

        // Full frame with the link up: A0,00,A0,01,...,A0,07
        repeat (6) @(posedge clk);
        #1 pulse_sync();
        base = cap.size();
        pulse_tick();
        wait_idle(1000);
        chk("p1_bytes", cap.size() - base, 16);
        for (int i = 0; i < 16; i++)
            chk("p2_byte", cap[base + i], (i % 2 == 0) ? 8'hA0 : 8'(i / 2));

        // Link down: sync word only
        chk("p3_broken", con_broken, 1'b1);
        base = cap.size();
        pulse_tick();
        wait_idle(1000);
        chk("p3_short_bytes", cap.size() - base, 2);
        chk("p3_short_hi", cap[base], 8'hA0);
        chk("p3_short_lo", cap[base + 1], 8'h00);
        pulse_sync();
        base = cap.size();
        pulse_tick();
        wait_idle(1000);
        chk("p3_full_bytes", cap.size() - base, 16);
        pulse_sync();
        repeat (100) @(posedge clk);
        #1 chk("p3_wd_100", con_broken, 1'b0);
        @(posedge clk);
        #1 chk("p3_wd_101", con_broken, 1'b1);

        // Three ticks in one frame: one pending frame, two overruns
        ov0 = n_overrun; fr0 = n_frames;
        pulse_sync();
        pulse_tick();
        repeat (20) @(posedge clk);
        #1 pulse_tick();
        repeat (20) @(posedge clk);
        #1 pulse_tick();
        repeat (20) @(posedge clk);
        #1 pulse_tick();
        wait_idle(2000);
        chk("p4_overruns", n_overrun - ov0, 2);
        chk("p4_frames", n_frames - fr0, 2);

        // tx_busy held across SEND_HI of word 1
        pulse_sync();
        base = n_starts;
        pulse_tick();
        wait_starts(base + 2, 200);
        begin
            int n = 0;
            while (tx_done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
            chk("p5_done_seen", tx_done, 1'b1);
        end
        force_busy = 1'b1;
        sb = n_starts;
        repeat (23) @(posedge clk);
        #1 chk("p5_no_start_busy", n_starts - sb, 0);
        force_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("p5_one_start", n_starts - sb, 1);
        wait_idle(1000);

        // Reset in WAIT_LO of word 3
        pulse_sync();
        base = n_starts;
        pulse_tick();
        wait_starts(base + 8, 400);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("p6_word_idx", word_idx, 4'd0);
        chk("p6_tx_data", tx_data, 8'd0);
        chk("p6_tx_start", tx_start, 1'b0);
        chk("p6_frame_active", frame_active, 1'b0);
        chk("p6_con_broken", con_broken, 1'b1);
        pulse_sync();
        base = cap.size();
        pulse_tick();
        wait_idle(1000);
        chk("p6_restart_bytes", cap.size() - base, 16);
        chk("p6_restart_idx", cap_idx[base], 4'd0);

        // Randomized traffic with a random word table
        for (int k = 0; k < 16; k++) word_tab[k] = 16'($urandom);
        fb_cnt = 0;
        for (int c = 0; c < 5000; c++) begin
            frame_tick = ($urandom_range(0, 59) == 0);
            rx_sync = ($urandom_range(0, 119) == 0);
            if (fb_cnt == 0 && $urandom_range(0, 199) == 0) fb_cnt = $urandom_range(1, 25);
            force_busy = (fb_cnt > 0);
            if (fb_cnt > 0) fb_cnt--;
            @(posedge clk); #1;
        end
        frame_tick = 1'b0; rx_sync = 1'b0; force_busy = 1'b0;
        wait_idle(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
